scan_window_controller: RTL and testbench

Sequencing controller that sits directly upstream of the scan-line window buffer. It accepts a raster pixel stream over a valid/ready handshake and drives the buffer's `enable`, `mode` and `dataIn`. It tracks row and column position, and at every stride-aligned full-window position it switches the buffer into loop-around mode. The winRow×winCol window is then emitted serially, with handshake and position tags, to the downstream classifier.

---
 rtl/scan_window_controller_pkg.sv | 19 +
 rtl/scan_window_controller_if.sv | 42 ++++
 rtl/scan_window_controller_raster_position_counter.sv | 77 +++++++
 rtl/scan_window_controller.sv | 118 +++++++++++
 tb/tb_scan_window_controller.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_window_controller_pkg.sv
// Shared types and width helpers for the scan-window sequencing controller.
package scan_window_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SERIAL = 2'd2
    } ctrlState_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int winSamples(input int winRow, input int winCol);
        return winRow * winCol;
    endfunction

endpackage

// File: rtl/scan_window_controller_if.sv
// Pixel-in, buffer-control and serial-window-out signals of the controller.
interface scan_window_controller_if #(
    parameter int bitwidth = 30,
    parameter int imRow    = 60,
    parameter int imCol    = 60
);
    import scan_window_controller_pkg::*;

    localparam int rowW = cntWidth(imRow);
    localparam int colW = cntWidth(imCol);

    logic                pixValid;
    logic                pixSof;
    logic [bitwidth-1:0] pixIn;
    logic                pixReady;
    logic                bufEnable;
    logic                bufMode;
    logic [bitwidth-1:0] bufDataIn;
    logic [bitwidth-1:0] bufSerialIn;
    logic                winOutValid;
    logic                winOutReady;
    logic [bitwidth-1:0] winOutData;
    logic                winOutFirst;
    logic                winOutLast;
    logic [rowW-1:0]     winPosRow;
    logic [colW-1:0]     winPosCol;

    modport master (
        input  pixValid, pixSof, pixIn, bufSerialIn, winOutReady,
        output pixReady, bufEnable, bufMode, bufDataIn,
               winOutValid, winOutData, winOutFirst, winOutLast,
               winPosRow, winPosCol
    );

    modport slave (
        output pixValid, pixSof, pixIn, bufSerialIn, winOutReady,
        input  pixReady, bufEnable, bufMode, bufDataIn,
               winOutValid, winOutData, winOutFirst, winOutLast,
               winPosRow, winPosCol
    );

endinterface

// File: rtl/scan_window_controller_raster_position_counter.sv
// Raster row/column tracking with SOF reload and stride phase counters;
// flags accepted pixels that complete a stride-aligned window.
module raster_position_counter
    import scan_window_controller_pkg::*;
#(
    parameter int winCol = 42,
    parameter int winRow = 42,
    parameter int imCol  = 60,
    parameter int imRow  = 60,
    parameter int stride = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           accept,
    input  logic                           sof,
    output logic                           trigger,
    output logic [cntWidth(imRow)-1:0]     trigRow,
    output logic [cntWidth(imCol)-1:0]     trigCol
);

    localparam int rowW = cntWidth(imRow);
    localparam int colW = cntWidth(imCol);
    localparam int strW = cntWidth(stride);

    localparam logic [colW-1:0] colLast     = colW'(imCol - 1);
    localparam logic [rowW-1:0] rowLast     = rowW'(imRow - 1);
    localparam logic [colW-1:0] colFirstWin = colW'(winCol - 1);
    localparam logic [rowW-1:0] rowFirstWin = rowW'(winRow - 1);
    localparam logic [strW-1:0] strReload   = strW'(stride - 1);

    // Registers hold the position the next accepted pixel will occupy.
    logic [colW-1:0] col, curCol;
    logic [rowW-1:0] row, curRow;
    logic [strW-1:0] colStr, rowStr, curColStr, curRowStr;

    // Phase counters read zero on aligned positions and reload after each hit.
    function automatic logic [strW-1:0] stepStride(input logic [strW-1:0] s);
        return (s == '0) ? strReload : s - strW'(1);
    endfunction

    assign curCol    = sof ? '0 : col;
    assign curRow    = sof ? '0 : row;
    assign curColStr = sof ? '0 : colStr;
    assign curRowStr = sof ? '0 : rowStr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col    <= '0;
            row    <= '0;
            colStr <= '0;
            rowStr <= '0;
        end else if (accept) begin
            if (curCol == colLast) begin
                col    <= '0;
                colStr <= '0;
                if (curRow == rowLast) begin
                    row    <= '0;
                    rowStr <= '0;
                end else begin
                    row    <= curRow + rowW'(1);
                    rowStr <= (curRow >= rowFirstWin) ? stepStride(curRowStr) : '0;
                end
            end else begin
                col    <= curCol + colW'(1);
                colStr <= (curCol >= colFirstWin) ? stepStride(curColStr) : '0;
                row    <= curRow;
                rowStr <= curRowStr;
            end
        end
    end

    assign trigger = accept && (curRow >= rowFirstWin) && (curCol >= colFirstWin)
                     && (curRowStr == '0) && (curColStr == '0);
    assign trigRow = curRow - rowFirstWin;
    assign trigCol = curCol - colFirstWin;

endmodule

// File: rtl/scan_window_controller.sv
// Streams raster pixels into the window buffer, then loops the buffer to
// emit each stride-aligned window serially with first/last and position tags.
module scan_window_controller
    import scan_window_controller_pkg::*;
#(
    parameter int winCol   = 42,
    parameter int winRow   = 42,
    parameter int imCol    = 60,
    parameter int imRow    = 60,
    parameter int stride   = 1,
    parameter int bitwidth = 30
) (
    input logic                      clock,
    input logic                      reset,
    scan_window_controller_if.master bus
);

    localparam int rowW  = cntWidth(imRow);
    localparam int colW  = cntWidth(imCol);
    localparam int nSamp = winSamples(winRow, winCol);
    localparam int kW    = cntWidth(nSamp);
    localparam logic [kW-1:0] kLast = kW'(nSamp - 1);

    ctrlState_t          state;
    logic [kW-1:0]       k;
    logic                pixReadyR;
    logic                bufModeR;
    logic                winValidR;
    logic [rowW-1:0]     posRow;
    logic [colW-1:0]     posCol;
    logic                accept;
    logic                trigger;
    logic [rowW-1:0]     trigRow;
    logic [colW-1:0]     trigCol;
    logic [bitwidth-1:0] pixData;

    assign accept = bus.pixValid & pixReadyR;

    raster_position_counter #(
        .winCol (winCol),
        .winRow (winRow),
        .imCol  (imCol),
        .imRow  (imRow),
        .stride (stride)
    ) uPosition (
        .clock   (clock),
        .reset   (reset),
        .accept  (accept),
        .sof     (bus.pixSof),
        .trigger (trigger),
        .trigRow (trigRow),
        .trigCol (trigCol)
    );

    // Handshake flags are registered alongside the state so that pixReady
    // never depends combinationally on winOutReady.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            pixReadyR <= 1'b0;
            bufModeR  <= 1'b0;
            winValidR <= 1'b0;
            posRow    <= '0;
            posCol    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= STREAM;
                    pixReadyR <= 1'b1;
                end
                STREAM: begin
                    if (trigger) begin
                        state     <= SERIAL;
                        pixReadyR <= 1'b0;
                        bufModeR  <= 1'b1;
                        winValidR <= 1'b1;
                        k         <= '0;
                        posRow    <= trigRow;
                        posCol    <= trigCol;
                    end
                end
                SERIAL: begin
                    if (bus.winOutReady) begin
                        if (k == kLast) begin
                            state     <= STREAM;
                            pixReadyR <= 1'b1;
                            bufModeR  <= 1'b0;
                            winValidR <= 1'b0;
                            k         <= '0;
                        end else begin
                            k <= k + kW'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pixReadyR <= 1'b0;
                    bufModeR  <= 1'b0;
                    winValidR <= 1'b0;
                end
            endcase
        end
    end

    assign pixData         = bus.pixIn;
    assign bus.bufDataIn   = pixData;
    assign bus.winOutData  = bus.bufSerialIn;
    assign bus.pixReady    = pixReadyR;
    assign bus.bufMode     = bufModeR;
    assign bus.winOutValid = winValidR;
    assign bus.bufEnable   = pixReadyR ? bus.pixValid : (winValidR & bus.winOutReady);
    assign bus.winOutFirst = winValidR & (k == '0);
    assign bus.winOutLast  = winValidR & (k == kLast);
    assign bus.winPosRow   = posRow;
    assign bus.winPosCol   = posCol;

endmodule

// File: tb/tb_scan_window_controller.sv
// Bench for scan_window_controller: 6x6 image, 3x3 window, strides 1 and 2.
module tb_scan_window_controller;

    localparam int WC = 3, WR = 3, IC = 6, IR = 6, BW = 8, NS = WC * WR;
    localparam int M_IDLE = 0, M_STREAM = 1, M_SERIAL = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;
    bit   toggleEn = 1'b0;

    always #5 clock = ~clock;

    scan_window_controller_if #(.bitwidth(BW), .imRow(IR), .imCol(IC)) if1 ();
    scan_window_controller_if #(.bitwidth(BW), .imRow(IR), .imCol(IC)) if2 ();

    scan_window_controller #(.winCol(WC), .winRow(WR), .imCol(IC), .imRow(IR),
                             .stride(1), .bitwidth(BW))
        dut1 (.clock(clock), .reset(reset), .bus(if1.master));

    scan_window_controller #(.winCol(WC), .winRow(WR), .imCol(IC), .imRow(IR),
                             .stride(2), .bitwidth(BW))
        dut2 (.clock(clock), .reset(reset), .bus(if2.master));

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for the stride-1 instance ----------------
    int mMode = M_IDLE, mRow = 0, mCol = 0, mK = 0, mPosR = 0, mPosC = 0, mAcc = 0;
    int tIdx[$], tRel[$], tPR[$], tPC[$];

    function automatic bit trig(input int r, input int c, input int s);
        return (r >= WR - 1) && (c >= WC - 1) && ((r - WR + 1) % s == 0) && ((c - WC + 1) % s == 0);
    endfunction

    initial begin : model
        int r, c, rel, nxt;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mMode = M_IDLE; mRow = 0; mCol = 0; mK = 0; mPosR = 0; mPosC = 0; mAcc = 0;
            end else begin
                case (mMode)
                    M_IDLE: mMode = M_STREAM;
                    M_STREAM: begin
                        if (if1.pixValid) begin
                            r   = if1.pixSof ? 0 : mRow;
                            c   = if1.pixSof ? 0 : mCol;
                            rel = if1.pixSof ? 0 : mAcc;
                            if (trig(r, c, 1)) begin
                                mMode = M_SERIAL; mK = 0;
                                mPosR = r - (WR - 1); mPosC = c - (WC - 1);
                                tIdx.push_back(r * IC + c); tRel.push_back(rel);
                                tPR.push_back(mPosR);       tPC.push_back(mPosC);
                            end
                            nxt  = (r * IC + c + 1) % (IC * IR);
                            mRow = nxt / IC;
                            mCol = nxt % IC;
                            mAcc = rel + 1;
                        end
                    end
                    default: begin
                        if (if1.winOutReady) begin
                            if (mK == NS - 1) begin mMode = M_STREAM; mK = 0; end
                            else mK++;
                        end
                    end
                endcase
            end
        end
    end

    // {pixReady, bufMode, winOutValid, bufEnable, winOutFirst, winOutLast}
    function automatic int expCtrl();
        bit st = (mMode == M_STREAM);
        bit se = (mMode == M_SERIAL);
        bit en = st ? if1.pixValid : (se & if1.winOutReady);
        return (st ? 32 : 0) + (se ? 16 : 0) + (se ? 8 : 0) + (en ? 4 : 0)
             + ((se && mK == 0) ? 2 : 0) + ((se && mK == NS - 1) ? 1 : 0);
    endfunction

    // ---------------- buffer emulation / downstream ready driver ----------------
    initial begin : readyDriver
        bit hs;
        forever begin
            @(negedge clock);
            hs = (mMode == M_SERIAL) && if1.winOutReady;
            @(posedge clock);
            #1;
            if (hs) if1.bufSerialIn = if1.bufSerialIn + 8'd1;
            if (toggleEn) if1.winOutReady = ~if1.winOutReady;
            else          if1.winOutReady = 1'b1;
        end
    end

    // ---------------- per-cycle compare process ----------------
    int firstCnt = 0, lastCnt = 0, hsCnt = 0;
    int q2R[$], q2C[$];

    initial begin : compare
        bit   prevStall = 1'b0;
        int   prevData  = 0;
        forever begin
            @(negedge clock);
            check("ctrl", int'({if1.pixReady, if1.bufMode, if1.winOutValid, if1.bufEnable,
                                if1.winOutFirst, if1.winOutLast}), expCtrl());
            check("winPos", int'(if1.winPosRow) * 16 + int'(if1.winPosCol), mPosR * 16 + mPosC);
            check("bufDataIn", int'(if1.bufDataIn), int'(if1.pixIn));
            check("winOutData", int'(if1.winOutData), int'(if1.bufSerialIn));
            if (prevStall && if1.winOutValid)
                check("stallHold", int'(if1.winOutData), prevData);
            if (!reset) hsCnt = 0;
            if (if1.winOutValid && if1.winOutReady) begin
                if (if1.winOutFirst) begin firstCnt++; hsCnt = 0; end
                hsCnt++;
                if (if1.winOutLast) begin
                    lastCnt++;
                    check("hsPerWindow", hsCnt, NS);
                end
            end
            if (if2.winOutValid && if2.winOutReady && if2.winOutFirst) begin
                q2R.push_back(int'(if2.winPosRow));
                q2C.push_back(int'(if2.winPosCol));
            end
            prevStall = reset && if1.winOutValid && !if1.winOutReady;
            prevData  = int'(if1.winOutData);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sendPix(input int sel, input int val, input bit sof);
        bit rdy;
        int guard;
        if (sel == 0) begin if1.pixValid = 1'b1; if1.pixIn = 8'(val); if1.pixSof = sof; end
        else          begin if2.pixValid = 1'b1; if2.pixIn = 8'(val); if2.pixSof = sof; end
        guard = 0;
        rdy   = 1'b0;
        while (!rdy && guard < 400) begin
            @(negedge clock);
            rdy = (sel == 0) ? if1.pixReady : if2.pixReady;
            guard++;
        end
        if (!rdy) check("pixAcceptTimeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic waitStream(input int sel);
        bit rdy;
        int guard;
        if (sel == 0) begin if1.pixValid = 1'b0; if1.pixSof = 1'b0; end
        else          begin if2.pixValid = 1'b0; if2.pixSof = 1'b0; end
        guard = 0;
        rdy   = 1'b0;
        while (!rdy && guard < 400) begin
            @(negedge clock);
            rdy = (sel == 0) ? if1.pixReady : if2.pixReady;
            guard++;
        end
        if (!rdy) check("streamTimeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic sendFrame(input int sel, input int n, input int sofA, input int sofB);
        for (int i = 0; i < n; i++) sendPix(sel, i % (IC * IR), (i == sofA) || (i == sofB));
        waitStream(sel);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stimulus
        int base, f0, l0, last, guard;
        if1.pixValid = 1'b0; if1.pixSof = 1'b0; if1.pixIn = '0; if1.bufSerialIn = '0; if1.winOutReady = 1'b1;
        if2.pixValid = 1'b0; if2.pixSof = 1'b0; if2.pixIn = '0; if2.bufSerialIn = 8'hA5; if2.winOutReady = 1'b1;

        // 1: reset values and release
        repeat (3) @(negedge clock);
        check("rstCtrl", int'({if1.pixReady, if1.bufEnable, if1.bufMode, if1.winOutValid,
                               if1.winOutFirst, if1.winOutLast}), 0);
        check("rstPos", int'(if1.winPosRow) + int'(if1.winPosCol), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("idlePixReady", int'(if1.pixReady), 0);
        @(negedge clock);
        check("streamPixReady", int'(if1.pixReady), 1);
        @(posedge clock); #1;

        // 2: full frame, stride 1
        base = tIdx.size(); f0 = firstCnt; l0 = lastCnt;
        sendFrame(0, 36, 0, -1);
        check("s2ModelWindows", tIdx.size() - base, 16);
        check("s2Firsts", firstCnt - f0, 16);
        check("s2Lasts", lastCnt - l0, 16);
        if (tIdx.size() > base) begin
            last = tIdx.size() - 1;
            check("s2FirstTrigPix", tIdx[base], 14);
            check("s2FirstTrigPos", tPR[base] * 16 + tPC[base], 0);
            check("s2LastTrigPix", tIdx[last], 35);
            check("s2LastTrigPos", tPR[last] * 16 + tPC[last], 3 * 16 + 3);
        end

        // 3: stride 2
        base = q2R.size();
        sendFrame(1, 36, 0, -1);
        check("s3Windows", q2R.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < q2R.size()) begin
                check("s3PosRow", q2R[base + i], (i / 2) * 2);
                check("s3PosCol", q2C[base + i], (i % 2) * 2);
            end
        end

        // 4: downstream ready toggling
        toggleEn = 1'b1;
        f0 = firstCnt; l0 = lastCnt;
        sendFrame(0, 36, 0, -1);
        toggleEn = 1'b0;
        check("s4Firsts", firstCnt - f0, 16);
        check("s4Lasts", lastCnt - l0, 16);
        @(posedge clock); #1;

        // 5: SOF re-asserted at pixel 20
        base = tIdx.size();
        sendFrame(0, 35, 0, 20);
        check("s5Windows", tIdx.size() - base, 5);
        if (tIdx.size() > base) begin
            last = tIdx.size() - 1;
            check("s5RestartRel", tRel[last], 14);
            check("s5RestartPix", tIdx[last], 14);
            check("s5RestartPos", tPR[last] * 16 + tPC[last], 0);
        end

        // 6: reset asserted at serial sample k=4
        for (int i = 0; i < 15; i++) sendPix(0, i, i == 0);
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(mMode == M_SERIAL && mK == 4) && guard < 100);
        check("s6ReachK4", mK, 4);
        #2;
        reset = 1'b0;
        if1.pixValid = 1'b0; if1.pixSof = 1'b0;
        @(negedge clock);
        check("s6WinOutValid", int'(if1.winOutValid), 0);
        check("s6PixReady", int'(if1.pixReady), 0);
        check("s6BufEnable", int'(if1.bufEnable), 0);
        check("s6ModelIdle", mMode * 256 + mRow * 16 + mCol, M_IDLE * 256);
        @(posedge clock); #1;
        reset = 1'b1;
        base = tIdx.size(); f0 = firstCnt;
        sendFrame(0, 15, -1, -1);
        check("s6Windows", tIdx.size() - base, 1);
        check("s6Firsts", firstCnt - f0, 1);
        if (tIdx.size() > base) begin
            last = tIdx.size() - 1;
            check("s6TrigPix", tIdx[last], 14);
            check("s6TrigPos", tPR[last] * 16 + tPC[last], 0);
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
